pipe_unit_scheduler: RTL and testbench

Issue scheduler for a fixed-latency, fully pipelined functional unit such as the 8-stage multiplier/divider pipeline in the LC4 out-of-order core. It arbitrates round-robin between two requesters and caps the number of operations in flight. It tracks each issued operation's source and tag through a shadow pipeline of matching depth, and presents a completion (source, tag) exactly LATENCY advancing cycles after issue. All state advances only when `gwe` is high; `flush` kills every in-flight operation.

---
 rtl/pipe_unit_scheduler.sv | 130 +++++++++++++
 tb/tb_pipe_unit_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_unit_scheduler.sv
// Issue scheduler for a fixed-latency pipelined unit: round-robin arbitration,
// an in-flight cap, and a shadow pipeline that reports (src, tag) at completion.
module pipe_unit_scheduler #(
    parameter int TAG_W        = 4,
    parameter int LATENCY      = 8,
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic             req0_valid,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic             grant0,
    output logic             grant1,
    output logic             issue_valid,
    output logic             issue_sel,
    output logic             done_valid,
    output logic             done_src,
    output logic [TAG_W-1:0] done_tag,
    output logic [CNT_W-1:0] inflight_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [LATENCY-1:0] valid_r;
    logic [LATENCY-1:0] src_r;
    logic [TAG_W-1:0]   tag_r [LATENCY];
    logic [CNT_W-1:0]   count_r;
    logic               rr_ptr_r;

    logic               retire_s;
    logic               can_issue_s;
    logic               issue_valid_s;
    logic               issue_sel_s;
    logic [TAG_W-1:0]   issue_tag_s;
    logic [CNT_W-1:0]   count_next_s;

    // A completion is reported only on an advancing, non-flush cycle, so it fires once.
    assign retire_s = valid_r[LATENCY-1] & gwe & ~flush;

    // Capacity check and round-robin arbitration; a retiring slot is reusable this cycle.
    always_comb begin
        can_issue_s   = 1'b0;
        issue_valid_s = 1'b0;
        issue_sel_s   = 1'b0;
        issue_tag_s   = {TAG_W{1'b0}};
        if (gwe && !flush && ((count_r < MAX_CNT) || retire_s)) begin
            can_issue_s = 1'b1;
        end else begin
            can_issue_s = 1'b0;
        end
        if (can_issue_s && req0_valid && req1_valid) begin
            issue_valid_s = 1'b1;
            issue_sel_s   = rr_ptr_r;
        end else if (can_issue_s && req0_valid) begin
            issue_valid_s = 1'b1;
            issue_sel_s   = 1'b0;
        end else if (can_issue_s && req1_valid) begin
            issue_valid_s = 1'b1;
            issue_sel_s   = 1'b1;
        end else begin
            issue_valid_s = 1'b0;
            issue_sel_s   = 1'b0;
        end
        if (issue_valid_s) begin
            issue_tag_s = issue_sel_s ? req1_tag : req0_tag;
        end else begin
            issue_tag_s = {TAG_W{1'b0}};
        end
    end

    // Next in-flight count: flush empties the unit, issue and retire cancel out.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (issue_valid_s && !retire_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (!issue_valid_s && retire_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Shadow pipeline of {valid, src, tag}, advancing only on gwe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {LATENCY{1'b0}};
            src_r   <= {LATENCY{1'b0}};
            for (int k = 0; k < LATENCY; k++) begin
                tag_r[k] <= {TAG_W{1'b0}};
            end
        end else if (gwe) begin
            valid_r  <= flush ? {LATENCY{1'b0}} : {valid_r[LATENCY-2:0], issue_valid_s};
            src_r    <= {src_r[LATENCY-2:0], issue_sel_s};
            tag_r[0] <= issue_tag_s;
            for (int k = 1; k < LATENCY; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // In-flight counter and round-robin pointer; the loser of a grant gets priority next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= {CNT_W{1'b0}};
            rr_ptr_r <= 1'b0;
        end else if (gwe) begin
            count_r  <= count_next_s;
            rr_ptr_r <= issue_valid_s ? ~issue_sel_s : rr_ptr_r;
        end
    end

    assign grant0         = issue_valid_s & ~issue_sel_s;
    assign grant1         = issue_valid_s & issue_sel_s;
    assign issue_valid    = issue_valid_s;
    assign issue_sel      = issue_sel_s;
    assign done_valid     = retire_s;
    assign done_src       = src_r[LATENCY-1];
    assign done_tag       = tag_r[LATENCY-1];
    assign inflight_count = count_r;
    assign busy           = (count_r != {CNT_W{1'b0}});

endmodule

// File: tb/tb_pipe_unit_scheduler.sv
// Bench for pipe_unit_scheduler: two instances (cap 8 and cap 4) checked every
// cycle against a deadline-FIFO reference model, plus directed timing checks.
module tb_pipe_unit_scheduler;

    localparam int LAT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       gwe;
    logic       flush;
    logic       req0_valid;
    logic [3:0] req0_tag;
    logic       req1_valid;
    logic [3:0] req1_tag;

    logic       a_g0, a_g1, a_iv, a_is, a_dv, a_src, a_busy;
    logic [3:0] a_tag;
    logic [4:0] a_cnt;
    logic       b_g0, b_g1, b_iv, b_is, b_dv, b_src, b_busy;
    logic [3:0] b_tag;
    logic [4:0] b_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: per instance, a FIFO of in-flight ops with their issue time
    int         adv;
    int         cap [2];
    int         m_n [2];
    int         m_adv [2][16];
    logic       m_src [2][16];
    logic [3:0] m_tag [2][16];
    logic       m_rr [2];

    pipe_unit_scheduler #(.TAG_W(4), .LATENCY(LAT), .MAX_INFLIGHT(8), .CNT_W(5)) u_a (
        .clk(clk), .rst(rst), .gwe(gwe),
        .req0_valid(req0_valid), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_tag(req1_tag), .flush(flush),
        .grant0(a_g0), .grant1(a_g1), .issue_valid(a_iv), .issue_sel(a_is),
        .done_valid(a_dv), .done_src(a_src), .done_tag(a_tag),
        .inflight_count(a_cnt), .busy(a_busy));

    pipe_unit_scheduler #(.TAG_W(4), .LATENCY(LAT), .MAX_INFLIGHT(4), .CNT_W(5)) u_b (
        .clk(clk), .rst(rst), .gwe(gwe),
        .req0_valid(req0_valid), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_tag(req1_tag), .flush(flush),
        .grant0(b_g0), .grant1(b_g1), .issue_valid(b_iv), .issue_sel(b_is),
        .done_valid(b_dv), .done_src(b_src), .done_tag(b_tag),
        .inflight_count(b_cnt), .busy(b_busy));

    always #5 clk = ~clk;

    function automatic logic [31:0] sample();
        return {a_g0, a_g1, a_iv, a_is & a_iv, a_dv, a_dv & a_src, a_dv ? a_tag : 4'h0, a_cnt, a_busy,
                b_g0, b_g1, b_iv, b_is & b_iv, b_dv, b_dv & b_src, b_dv ? b_tag : 4'h0, b_cnt, b_busy};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]  = 0;
            m_rr[i] = 1'b0;
        end
    endtask

    // drive one cycle, return observed and model-expected vectors, advance past the edge
    task automatic step(input logic v0, input logic [3:0] t0, input logic v1, input logic [3:0] t1,
                        input logic g, input logic f, output logic [31:0] obs, output logic [31:0] exp);
        req0_valid = v0; req0_tag = t0; req1_valid = v1; req1_tag = t1; gwe = g; flush = f;
        #2;
        obs = sample();
        for (int i = 0; i < 2; i++) begin
            logic due, dv, can, iv, sel;
            logic [15:0] e;
            due = (m_n[i] > 0) && ((adv - m_adv[i][0]) == LAT);
            dv  = g && !f && due;
            can = g && !f && ((m_n[i] < cap[i]) || dv);
            iv  = can && (v0 || v1);
            sel = iv && ((v0 && v1) ? m_rr[i] : !v0);
            e = {iv & !sel, iv & sel, iv, sel, dv, dv & m_src[i][0],
                 dv ? m_tag[i][0] : 4'h0, 5'(m_n[i]), m_n[i] != 0};
            if (i == 0) exp[31:16] = e; else exp[15:0] = e;
            if (g) begin
                if (f) begin
                    m_n[i] = 0;
                end else begin
                    if (dv) begin
                        for (int k = 0; k < 15; k++) begin
                            m_adv[i][k] = m_adv[i][k+1];
                            m_src[i][k] = m_src[i][k+1];
                            m_tag[i][k] = m_tag[i][k+1];
                        end
                        m_n[i]--;
                    end
                    if (iv) begin
                        m_adv[i][m_n[i]] = adv;
                        m_src[i][m_n[i]] = sel;
                        m_tag[i][m_n[i]] = sel ? t1 : t0;
                        m_n[i]++;
                        m_rr[i] = !sel;
                    end
                end
            end
        end
        if (g) adv++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        #2;
        obs = sample();
        checks++;
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", obs, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_issue();
        logic [31:0] obs, exp;
        int ndone = 0, dcyc = -1;
        for (int c = 0; c < 12; c++) begin
            step(c == 0, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_issue cyc %0d got %h expected %h", c, obs, exp);
            end
            if (obs[27]) begin ndone++; dcyc = c; end
        end
        checks++;
        if (ndone != 1 || dcyc != 8) begin
            errors++;
            $display("FAIL single_issue_latency got %0d done at cycle %0d expected 1 at cycle 8", ndone, dcyc);
        end
    endtask

    task automatic test_contention();
        logic [31:0] obs, exp;
        for (int c = 0; c < 28; c++) begin
            step(c < 16, 4'(c / 2), c < 16, 4'(c / 2), 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL contention cyc %0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_cap();
        logic [31:0] obs, exp;
        for (int c = 0; c < 24; c++) begin
            step(c < 14, 4'(c), 1'b0, 4'd0, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL cap cyc %0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] obs, exp;
        int ndone = 0, dcyc = -1;
        for (int c = 0; c < 16; c++) begin
            step(c <= 4, (c == 4) ? 4'd6 : 4'(c + 1), 1'b0, 4'd0, 1'b1, c == 3, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL flush cyc %0d got %h expected %h", c, obs, exp);
            end
            if (obs[27]) begin ndone++; dcyc = c; end
        end
        checks++;
        if (ndone != 1 || dcyc != 12) begin
            errors++;
            $display("FAIL flush_reissue got %0d done at cycle %0d expected 1 at cycle 12", ndone, dcyc);
        end
    endtask

    task automatic test_stall();
        logic [31:0] obs, exp;
        int ndone = 0, dcyc = -1;
        for (int c = 0; c < 14; c++) begin
            step(c == 0 || c == 3 || c == 4, 4'd9, 1'b0, 4'd0, !(c == 3 || c == 4), 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stall cyc %0d got %h expected %h", c, obs, exp);
            end
            if (obs[27]) begin ndone++; dcyc = c; end
        end
        checks++;
        if (ndone != 1 || dcyc != 10) begin
            errors++;
            $display("FAIL stall_latency got %0d done at cycle %0d expected 1 at cycle 10", ndone, dcyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs, exp;
        int ndone = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 4'(c + 10), 1'b0, 4'd0, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_fill cyc %0d got %h expected %h", c, obs, exp);
            end
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0; gwe = 1'b1; flush = 1'b0;
        rst = 1'b1;
        #1;
        obs = sample();
        checks++;
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_async got %h expected %h", obs, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 12; c++) begin
            step(c == 0, 4'd3, c == 0, 4'd4, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d got %h expected %h", c, obs, exp);
            end
            if (obs[27] && c != 8) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_mid_stale got %0d stale completions expected 0", ndone);
        end
    endtask

    task automatic test_random();
        logic [31:0] obs, exp;
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cyc %0d got %h expected %h", c, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; gwe = 1'b0; flush = 1'b0;
        req0_valid = 1'b0; req0_tag = 4'd0; req1_valid = 1'b0; req1_tag = 4'd0;
        adv = 0;
        cap[0] = 8;
        cap[1] = 4;
        model_reset();
        test_reset();
        test_single_issue();
        test_contention();
        test_cap();
        test_flush();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
